// File: rtl/flag_branch_unit_if.sv
// Flag/branch bus between the Execute stage and the flag_branch_unit.
// The master drives the EX-slot information; the slave returns the
// committed condition codes and the PC redirect.
interface flag_branch_unit_if #(
    parameter int unsigned PC_WIDTH = 16
);
    logic                ex_valid;
    logic                stall;
    logic [3:0]          alu_op;
    logic [2:0]          alu_flag;
    logic [2:0]          br_type;
    logic [PC_WIDTH-1:0] br_target;
    logic                int_save;
    logic                rti_restore;
    logic [2:0]          ccr;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                squash;

    modport master (
        output ex_valid, stall, alu_op, alu_flag, br_type, br_target,
               int_save, rti_restore,
        input  ccr, redirect, redirect_pc, squash
    );

    modport slave (
        input  ex_valid, stall, alu_op, alu_flag, br_type, br_target,
               int_save, rti_restore,
        output ccr, redirect, redirect_pc, squash
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Execute-stage condition-code register with per-opcode flag write masks,
// jump resolution against the committed CCR, registered PC redirect,
// wrong-path squash window and a single-level interrupt shadow of the CCR.
module flag_branch_unit #(
    parameter int unsigned PC_WIDTH      = 16,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    flag_branch_unit_if.slave bus
);
    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          ccr_q;
    logic [2:0]          shadow_q;
    logic                redirect_q;
    logic [PC_WIDTH-1:0] redirect_pc_q;

    logic [2:0]          mask;
    logic [2:0]          clr;
    logic                cond;
    logic                accept;
    logic                taken;
    logic [2:0]          ccr_upd;

    // Flag write mask {N,C,Z}; any branch instruction writes no flags.
    always_comb begin
        mask = '0;
        if (bus.br_type == 3'b000) begin
            case (bus.alu_op)
                4'b0001, 4'b0101, 4'b0110:                     mask = 3'b101;
                4'b0010, 4'b0100, 4'b0111,
                4'b1000, 4'b1011, 4'b1100:                     mask = 3'b111;
                4'b1001, 4'b1010:                              mask = 3'b010;
                default:                                       mask = '0;
            endcase
        end
    end

    // Jump condition tested against the committed CCR, plus the flag to clear.
    always_comb begin
        cond = 1'b0;
        clr  = '0;
        case (bus.br_type)
            3'b001: begin cond = ccr_q[0]; clr = 3'b001; end
            3'b010: begin cond = ccr_q[2]; clr = 3'b100; end
            3'b011: begin cond = ccr_q[1]; clr = 3'b010; end
            3'b100: begin cond = 1'b1;     clr = 3'b000; end
            default: begin cond = 1'b0;    clr = 3'b000; end
        endcase
    end

    // Instruction acceptance and the CCR value an accepted instruction produces.
    always_comb begin
        accept  = bus.ex_valid && (state_q == RUN);
        taken   = accept && cond;
        ccr_upd = ccr_q;
        if (accept) begin
            ccr_upd = (ccr_q & ~mask) | (bus.alu_flag & mask);
            if (taken) begin
                ccr_upd = ccr_upd & ~clr;
            end
        end
    end

    // State register; stall freezes the squash counter along with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (!bus.stall) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a taken jump opens the squash window, which counts down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (taken) begin
                    state_d = SQUASH;
                    cnt_d   = SQ_LOAD;
                end
            end
            SQUASH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // CCR, shadow and redirect registers; restore beats save beats ALU update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q         <= '0;
            shadow_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (!bus.stall) begin
            if (bus.rti_restore) begin
                ccr_q <= shadow_q;
            end else begin
                ccr_q <= ccr_upd;
                if (bus.int_save) begin
                    shadow_q <= ccr_q;
                end
            end
            redirect_q <= taken;
            if (taken) begin
                redirect_pc_q <= bus.br_target;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.ccr         = ccr_q;
        bus.redirect    = redirect_q;
        bus.redirect_pc = redirect_pc_q;
        bus.squash      = (state_q == SQUASH);
    end
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed-vector bench for flag_branch_unit (PC_WIDTH=16, SQUASH_CYCLES=2).
module tb_flag_branch_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    flag_branch_unit_if #(.PC_WIDTH(16)) bus ();

    flag_branch_unit #(
        .PC_WIDTH      (16),
        .SQUASH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_ccr, input logic e_red,
                             input logic [15:0] e_pc, input logic e_sq);
        check({tag, ".ccr"},         32'(bus.ccr),         32'(e_ccr));
        check({tag, ".redirect"},    32'(bus.redirect),    32'(e_red));
        check({tag, ".redirect_pc"}, 32'(bus.redirect_pc), 32'(e_pc));
        check({tag, ".squash"},      32'(bus.squash),      32'(e_sq));
    endtask

    task automatic idle();
        bus.ex_valid    = 1'b0;
        bus.stall       = 1'b0;
        bus.alu_op      = 4'b0000;
        bus.alu_flag    = 3'b000;
        bus.br_type     = 3'b000;
        bus.br_target   = 16'h0000;
        bus.int_save    = 1'b0;
        bus.rti_restore = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [2:0] fl);
        idle();
        bus.ex_valid = 1'b1;
        bus.alu_op   = op;
        bus.alu_flag = fl;
    endtask

    task automatic jump(input logic [2:0] bt, input logic [15:0] tgt);
        idle();
        bus.ex_valid  = 1'b1;
        bus.br_type   = bt;
        bus.br_target = tgt;
        bus.alu_op    = 4'b0010;
        bus.alu_flag  = 3'b111;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 3'b000, 1'b0, 16'h0000, 1'b0);

        // Flag masks
        alu(4'b0010, 3'b101); tick(); check("op0010", 32'(bus.ccr), 32'b101);
        alu(4'b0101, 3'b010); tick(); check("op0101_nz", 32'(bus.ccr), 32'b000);
        alu(4'b1001, 3'b010); tick(); check("op1001_c", 32'(bus.ccr), 32'b010);
        alu(4'b0101, 3'b101); tick(); check("op0101_ckept", 32'(bus.ccr), 32'b111);
        alu(4'b0000, 3'b000); tick(); check("op0000_none", 32'(bus.ccr), 32'b111);
        alu(4'b1101, 3'b000); tick(); check("op1101_none", 32'(bus.ccr), 32'b111);
        alu(4'b0010, 3'b000); bus.ex_valid = 1'b0; tick();
        check("invalid_ignored", 32'(bus.ccr), 32'b111);
        alu(4'b0010, 3'b000); bus.stall = 1'b1; tick();
        check("stall_ignored", 32'(bus.ccr), 32'b111);

        // Taken JZ, squash window, jump inside squash ignored
        alu(4'b0010, 3'b001); tick(); check("set001", 32'(bus.ccr), 32'b001);
        jump(3'b001, 16'h0040); tick();
        check_all("jz_taken", 3'b000, 1'b1, 16'h0040, 1'b1);
        alu(4'b0010, 3'b111); tick();
        check_all("jz_sq1", 3'b000, 1'b0, 16'h0040, 1'b1);
        jump(3'b100, 16'h5555); tick();
        check_all("jz_sq_end", 3'b000, 1'b0, 16'h0040, 1'b0);

        // Not-taken JC, not-taken JZ, then JMP leaves CCR unchanged
        jump(3'b011, 16'h0099); tick();
        check_all("jc_not_taken", 3'b000, 1'b0, 16'h0040, 1'b0);
        alu(4'b0010, 3'b110); tick(); check("set110", 32'(bus.ccr), 32'b110);
        jump(3'b001, 16'h0077); tick();
        check_all("jz_not_taken", 3'b110, 1'b0, 16'h0040, 1'b0);
        jump(3'b100, 16'h1234); tick();
        check_all("jmp_taken", 3'b110, 1'b1, 16'h1234, 1'b1);
        idle(); tick(); tick();
        check_all("jmp_sq_end", 3'b110, 1'b0, 16'h1234, 1'b0);

        // Shadow save/restore
        alu(4'b0100, 3'b001); bus.int_save = 1'b1; tick();
        check("save_with_update", 32'(bus.ccr), 32'b001);
        idle(); bus.rti_restore = 1'b1; tick();
        check("restore", 32'(bus.ccr), 32'b110);
        alu(4'b0010, 3'b011); tick(); check("set011", 32'(bus.ccr), 32'b011);
        idle(); bus.int_save = 1'b1; bus.rti_restore = 1'b1; tick();
        check("restore_beats_save", 32'(bus.ccr), 32'b110);
        alu(4'b0010, 3'b000); tick(); check("set000", 32'(bus.ccr), 32'b000);
        idle(); bus.rti_restore = 1'b1; tick();
        check("shadow_kept", 32'(bus.ccr), 32'b110);

        // Taken JN with stall during the redirect cycle
        jump(3'b010, 16'h0abc); tick();
        check_all("jn_taken", 3'b010, 1'b1, 16'h0abc, 1'b1);
        idle(); bus.stall = 1'b1; bus.rti_restore = 1'b1; tick();
        check_all("jn_stall1", 3'b010, 1'b1, 16'h0abc, 1'b1);
        tick();
        check_all("jn_stall2", 3'b010, 1'b1, 16'h0abc, 1'b1);
        idle(); tick();
        check_all("jn_sq2", 3'b010, 1'b0, 16'h0abc, 1'b1);
        tick();
        check_all("jn_sq_end", 3'b010, 1'b0, 16'h0abc, 1'b0);

        // Reset during squash
        jump(3'b100, 16'h00ff); tick();
        check_all("jmp2_taken", 3'b010, 1'b1, 16'h00ff, 1'b1);
        idle(); rst = 1'b1; bus.stall = 1'b1; tick();
        rst = 1'b0;
        check_all("mid_sq_reset", 3'b000, 1'b0, 16'h0000, 1'b0);
        jump(3'b001, 16'h0033); tick();
        check_all("jz_after_reset", 3'b000, 1'b0, 16'h0000, 1'b0);
        idle(); bus.rti_restore = 1'b1; tick();
        check("shadow_reset", 32'(bus.ccr), 32'b000);

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
